// File: rtl/jtag_scan_controller_if.sv
// jtag_scan_controller_if: scan request, JTAG pin and status bundle.
// slave is the controller side, master is the request source / target model.
interface jtag_scan_controller_if;
    logic        start;
    logic [2:0]  instrWidth;
    logic [4:0]  instrOpcode;
    logic [5:0]  vectorWidth;
    logic [31:0] testVector;
    logic        tdo;
    logic        tms;
    logic        tdi;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] tdoData;
    logic [3:0]  tapState;
    modport slave (
        input  start, instrWidth, instrOpcode, vectorWidth, testVector, tdo,
        output tms, tdi, busy, done, error, tdoData, tapState
    );
    modport master (
        output start, instrWidth, instrOpcode, vectorWidth, testVector, tdo,
        input  tms, tdi, busy, done, error, tdoData, tapState
    );
endinterface

// File: rtl/jtag_scan_controller.sv
// jtag_scan_controller: JTAG master running one IR scan then one DR scan per request.
// Define JTAG_TLR_ON_START_EN to force Test-Logic-Reset before every accepted scan.
module jtag_scan_controller #(
    parameter int MAX_VECTOR_WIDTH = 32,
    parameter int MAX_INSTR_WIDTH  = 5,
    parameter int TLR_TMS_CYCLES   = 5
) (
    input logic clk,
    input logic reset,
    jtag_scan_controller_if.slave bus
);
`ifdef JTAG_TLR_ON_START_EN
    localparam bit TLR_EN = 1'b1;
`else
    localparam bit TLR_EN = 1'b0;
`endif
    localparam logic [3:0] RESET = 4'd0, IDLE = 4'd1, DR_SCAN = 4'd2, IR_SCAN = 4'd3,
        CAPTURE_IR = 4'd4, SHIFT_IR = 4'd5, EXIT1_IR = 4'd6, PAUSE_IR = 4'd7,
        EXIT2_IR = 4'd8, UPDATE_IR = 4'd9, CAPTURE_DR = 4'd10, SHIFT_DR = 4'd11,
        EXIT1_DR = 4'd12, PAUSE_DR = 4'd13, EXIT2_DR = 4'd14, UPDATE_DR = 4'd15;
    logic [3:0]  nxt;
    logic [2:0]  iw;
    logic [5:0]  vw, cnt;
    logic [4:0]  ir_sr;
    logic [31:0] dr_sr;
    logic [7:0]  pcnt;
    logic        ir_phase, pre, idle_ok, legal, accept, shift_next, last, tms_next;
    // tapState follows the registered tms, so nxt is the state this edge lands in
    always_comb begin
        case (bus.tapState)
            RESET:      nxt = bus.tms ? RESET : IDLE;
            IDLE:       nxt = bus.tms ? DR_SCAN : IDLE;
            DR_SCAN:    nxt = bus.tms ? IR_SCAN : CAPTURE_DR;
            IR_SCAN:    nxt = bus.tms ? RESET : CAPTURE_IR;
            CAPTURE_IR: nxt = bus.tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:   nxt = bus.tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:   nxt = bus.tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   nxt = bus.tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:   nxt = bus.tms ? UPDATE_IR : SHIFT_IR;
            CAPTURE_DR: nxt = bus.tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:   nxt = bus.tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:   nxt = bus.tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   nxt = bus.tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:   nxt = bus.tms ? UPDATE_DR : SHIFT_DR;
            default:    nxt = bus.tms ? DR_SCAN : IDLE;
        endcase
    end
    assign idle_ok    = !bus.busy && bus.tapState == IDLE;
    assign legal      = bus.instrWidth >= 3'd3 && int'(bus.instrWidth) <= MAX_INSTR_WIDTH &&
                        bus.vectorWidth[2:0] == 3'd0 && bus.vectorWidth != 6'd0 &&
                        int'(bus.vectorWidth) <= MAX_VECTOR_WIDTH;
    assign accept     = bus.start && idle_ok && legal;
    assign shift_next = nxt == SHIFT_IR || nxt == SHIFT_DR;
    assign last       = cnt == (nxt == SHIFT_IR ? {3'b0, iw} : vw) - 6'd1;
    // tms is chosen for the state being entered: it is what moves us out of it
    assign tms_next   = nxt == DR_SCAN ? ir_phase : shift_next ? last :
                        nxt inside {EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR, EXIT1_DR, PAUSE_DR, EXIT2_DR};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tms      <= 1'b1;
            bus.tdi      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
            bus.tdoData  <= '0;
            bus.tapState <= RESET;
            iw           <= '0;
            vw           <= '0;
            cnt          <= '0;
            ir_sr        <= '0;
            dr_sr        <= '0;
            pcnt         <= '0;
            ir_phase     <= 1'b0;
            pre          <= 1'b0;
        end else begin
            bus.tapState <= nxt;
            bus.done     <= bus.busy && bus.tapState == UPDATE_DR && !bus.tms;
            bus.busy     <= accept || (bus.busy && !(bus.tapState == UPDATE_DR && !bus.tms));
            bus.error    <= bus.start && idle_ok && !legal;
            cnt          <= shift_next ? cnt + 6'd1 : 6'd0;
            if (bus.tapState == SHIFT_DR) bus.tdoData[5'(cnt - 6'd1)] <= bus.tdo;
            if (accept) begin
                iw          <= bus.instrWidth;
                vw          <= bus.vectorWidth;
                ir_sr       <= bus.instrOpcode;
                dr_sr       <= bus.testVector;
                ir_phase    <= 1'b1;
                bus.tdoData <= '0;
                bus.tms     <= 1'b1;
                bus.tdi     <= 1'b0;
                pre         <= TLR_EN;
                pcnt        <= 8'd1;
            end else if (pre) begin
                bus.tms <= int'(pcnt) != TLR_TMS_CYCLES;
                pre     <= (int'(pcnt) <= TLR_TMS_CYCLES);
                pcnt    <= pcnt + 8'd1;
            end else begin
                bus.tms <= tms_next;
                bus.tdi <= nxt == SHIFT_IR ? ir_sr[0] : nxt == SHIFT_DR ? dr_sr[0] : 1'b0;
                if (nxt == SHIFT_IR) ir_sr <= ir_sr >> 1;
                if (nxt == SHIFT_DR) dr_sr <= dr_sr >> 1;
                if (nxt == EXIT1_IR) ir_phase <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jtag_scan_controller.sv
// tb_jtag_scan_controller: randomized scans against a TAP-path reference model.
module tb_jtag_scan_controller;
    localparam logic [3:0] RESET = 4'd0, IDLE = 4'd1, DR_SCAN = 4'd2, IR_SCAN = 4'd3,
        CAPTURE_IR = 4'd4, SHIFT_IR = 4'd5, EXIT1_IR = 4'd6, UPDATE_IR = 4'd9,
        CAPTURE_DR = 4'd10, SHIFT_DR = 4'd11, EXIT1_DR = 4'd12, UPDATE_DR = 4'd15;
    localparam int TLR = 5;
`ifdef JTAG_TLR_ON_START_EN
    localparam int EXTRA = TLR + 1;
`else
    localparam int EXTRA = 0;
`endif
    logic clk, reset, tdo_v;
    int   tdo_mode, n_tests, n_fail;
    logic [3:0] q_st[$];
    logic q_ms[$], q_di[$];

    jtag_scan_controller_if bus ();
    jtag_scan_controller #(.MAX_VECTOR_WIDTH(32), .MAX_INSTR_WIDTH(5), .TLR_TMS_CYCLES(TLR))
        dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.tdo = tdo_mode == 0 ? bus.tdi : tdo_mode == 1 ? 1'b1 : tdo_mode == 2 ? 1'b0 : tdo_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic t, input logic d);
        q_st.push_back(s);
        q_ms.push_back(t);
        q_di.push_back(d);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tms"}, 32'(bus.tms), 32'd1);
        check({tag, "_tdi"}, 32'(bus.tdi), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_tdoData"}, bus.tdoData, 32'd0);
        check({tag, "_tap"}, 32'(bus.tapState), 32'(RESET));
    endtask

    // called at a negedge while reset is high
    task automatic do_release();
        reset = 1'b0;
        @(negedge clk);
        check("rel1_tms", 32'(bus.tms), 32'd0);
        check("rel1_tap", 32'(bus.tapState), 32'(RESET));
        @(negedge clk);
        check("rel2_tms", 32'(bus.tms), 32'd0);
        check("rel2_tap", 32'(bus.tapState), 32'(IDLE));
        check("rel2_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic set_req(input int iw, input logic [4:0] op, input int vw, input logic [31:0] vec);
        bus.start       = 1'b1;
        bus.instrWidth  = 3'(iw);
        bus.instrOpcode = op;
        bus.vectorWidth = 6'(vw);
        bus.testVector  = vec;
    endtask

    // start is already applied; returns at the negedge of the done cycle (or after reset when aborted)
    task automatic run_scan(input int iw, input logic [4:0] op, input int vw, input logic [31:0] vec,
                            input int abort_bit);
        logic [31:0] exp_data;
        int kdr, first_done, last;
        exp_data = '0;
        kdr = 0;
        first_done = -1;
        q_st.delete();
        q_ms.delete();
        q_di.delete();
`ifdef JTAG_TLR_ON_START_EN
        push(IDLE, 1, 0); push(DR_SCAN, 1, 0); push(IR_SCAN, 1, 0);
        for (int i = 3; i < TLR; i++) push(RESET, 1, 0);
        push(RESET, 0, 0);
`endif
        push(IDLE, 1, 0); push(DR_SCAN, 1, 0); push(IR_SCAN, 0, 0); push(CAPTURE_IR, 0, 0);
        for (int k = 0; k < iw; k++) push(SHIFT_IR, k == iw - 1, op[k]);
        push(EXIT1_IR, 1, 0); push(UPDATE_IR, 1, 0); push(DR_SCAN, 0, 0); push(CAPTURE_DR, 0, 0);
        for (int k = 0; k < vw; k++) push(SHIFT_DR, k == vw - 1, vec[k]);
        push(EXIT1_DR, 1, 0); push(UPDATE_DR, 0, 0); push(IDLE, 0, 0);
        last = q_st.size() - 1;
        @(posedge clk);
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            if (j == 0) begin
                bus.start = 1'b0;
                set_req($urandom_range(3, 5), 5'($urandom), 8 * $urandom_range(1, 4), $urandom);
                bus.start = 1'b0;
            end
            if (j == 2) bus.start = 1'b1;
            if (j == 3) bus.start = 1'b0;
            tdo_v = 1'($urandom);
            #1;
            check("tms", 32'(bus.tms), 32'(q_ms[j]));
            check("tdi", 32'(bus.tdi), 32'(q_di[j]));
            check("tap", 32'(bus.tapState), 32'(q_st[j]));
            check("busy", 32'(bus.busy), 32'(j < last));
            check("done", 32'(bus.done), 32'(j == last));
            check("error", 32'(bus.error), 32'd0);
            if (bus.done && first_done < 0) first_done = j;
            if (q_st[j] == SHIFT_DR) begin
                exp_data[kdr] = tdo_mode == 0 ? q_di[j] : tdo_mode == 1 ? 1'b1 : tdo_mode == 2 ? 1'b0 : tdo_v;
                if (kdr == abort_bit) begin
                    #1 reset = 1'b1;
                    #1 check_reset_vals("midscan");
                    @(negedge clk);
                    return;
                end
                kdr++;
            end
        end
        check("latency", first_done, iw + vw + 10 + EXTRA);
        check("tdoData", bus.tdoData, exp_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int iw, vw;
        n_tests = 0;
        n_fail = 0;
        tdo_mode = 0;
        tdo_v = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.instrWidth = '0;
        bus.instrOpcode = '0;
        bus.vectorWidth = '0;
        bus.testVector = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        do_release();
        // directed: IR 5 / DR 8 looped back
        set_req(5, 5'b00110, 8, 32'h000000A5);
        run_scan(5, 5'b00110, 8, 32'h000000A5, -1);
        check("a5_data", bus.tdoData, 32'h000000A5);
        @(negedge clk);
        check("a5_hold", bus.tdoData, 32'h000000A5);
        check("a5_done_pulse", 32'(bus.done), 32'd0);
        // directed: IR 3 / DR 32 with tdo tied high
        tdo_mode = 1;
        set_req(3, 5'b10101, 32, 32'hDEADBEEF);
        run_scan(3, 5'b10101, 32, 32'hDEADBEEF, -1);
        check("ff_data", bus.tdoData, 32'hFFFFFFFF);
        @(negedge clk);
        // illegal widths
        for (int i = 0; i < 7; i++) begin
            iw = i == 0 ? 5 : $urandom_range(0, 7);
            vw = i == 0 ? 12 : $urandom_range(0, 63);
            if (iw inside {3, 4, 5} && vw inside {8, 16, 24, 32}) vw = 12;
            set_req(iw, 5'($urandom), vw, $urandom);
            @(negedge clk);
            bus.start = 1'b0;
            check("ill_error", 32'(bus.error), 32'd1);
            check("ill_busy", 32'(bus.busy), 32'd0);
            check("ill_tms", 32'(bus.tms), 32'd0);
            @(negedge clk);
            check("ill_error_pulse", 32'(bus.error), 32'd0);
            check("ill_tap", 32'(bus.tapState), 32'(IDLE));
            check("ill_data_hold", bus.tdoData, 32'hFFFFFFFF);
        end
        // reset during ShiftDr bit 4, then a normal scan
        tdo_mode = 0;
        set_req(5, 5'b01011, 8, 32'h0000003C);
        run_scan(5, 5'b01011, 8, 32'h0000003C, 4);
        do_release();
        set_req(4, 5'b00101, 16, 32'h00001234);
        run_scan(4, 5'b00101, 16, 32'h00001234, -1);
        // random scans, some issued back-to-back in the done cycle
        for (int n = 0; n < 20; n++) begin
            logic [4:0]  op;
            logic [31:0] vec;
            int gap;
            iw = $urandom_range(3, 5);
            vw = 8 * $urandom_range(1, 4);
            op = 5'($urandom);
            vec = $urandom;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            tdo_mode = $urandom_range(0, 3);
            set_req(iw, op, vw, vec);
            run_scan(iw, op, vw, vec, -1);
        end
        @(negedge clk);
        check("final_idle", 32'(bus.tapState), 32'(IDLE));
        check("final_busy", 32'(bus.busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
